// File: rtl/fetch_pkg.sv
// -----------------------------------------------------------------------------
// fetch_pkg
// Shared types for the instruction fetch queue.
//   fetch_state_t : request state machine encoding (IDLE, REQ, WAIT, DROP)
//   fifo_entry_t  : one prefetched instruction together with its word address
//   IFQ_ADDR_W / IFQ_DATA_W : widths baked into fifo_entry_t; the top-level
//                   ADDR_W / DATA_W parameters default to these and must match.
//   DEFAULT_RESET_PC : first fetch address after reset.
// -----------------------------------------------------------------------------
package fetch_pkg;

  localparam int IFQ_ADDR_W = 16;
  localparam int IFQ_DATA_W = 16;

  localparam logic [IFQ_ADDR_W-1:0] DEFAULT_RESET_PC = 16'h0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,  // no request outstanding, waiting for FIFO space
    REQ  = 2'd1,  // imem_req held high until imem_gnt
    WAIT = 2'd2,  // granted, response still to come and will be kept
    DROP = 2'd3   // granted, response still to come and will be discarded
  } fetch_state_t;

  typedef struct packed {
    logic [IFQ_ADDR_W-1:0] pc;
    logic [IFQ_DATA_W-1:0] data;
  } fifo_entry_t;

endpackage

// File: rtl/ifq_fifo.sv
// -----------------------------------------------------------------------------
// ifq_fifo
// Synchronous prefetch FIFO of fifo_entry_t, DEPTH entries (power of two >= 2).
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   flush_i       : empties the FIFO; wins over push and pop in the same cycle
//   push_i        : write entry_i at the tail
//   entry_i       : entry to write
//   pop_i         : drop the head entry (ignored when empty)
//   head_o        : current head entry (stale content when empty_o is high)
//   empty_o       : no valid entries
//   count_o       : number of valid entries, 0..DEPTH
// -----------------------------------------------------------------------------
module ifq_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     flush_i,
  input  logic                     push_i,
  input  fifo_entry_t              entry_i,
  input  logic                     pop_i,
  output fifo_entry_t              head_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int PW = $clog2(DEPTH);

  fifo_entry_t   mem_q [DEPTH];
  logic [PW-1:0] rd_ptr_q;
  logic [PW-1:0] wr_ptr_q;
  logic [PW:0]   count_q;
  logic          full;
  logic          do_push;
  logic          do_pop;

  assign empty_o = (count_q == '0);
  assign full    = (count_q == (PW+1)'(DEPTH));
  assign do_pop  = pop_i && !empty_o;
  // A push into a full FIFO is only legal when the head leaves the same cycle.
  assign do_push = push_i && (!full || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else if (flush_i) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      count_q <= count_q + (PW+1)'(do_push) - (PW+1)'(do_pop);
    end
  end

  // Storage needs no reset: count_q qualifies every slot.
  always_ff @(posedge clk_i) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= entry_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// instr_fetch_queue
// Fetch stage in front of the single-cycle decode/execute datapath. Issues one
// word-addressed fetch at a time to a variable-latency instruction memory,
// buffers returned instructions in a prefetch FIFO and hands {instr, pc} to
// decode. A branch/jump redirect flushes the FIFO and discards any response
// still in flight.
//
// Ports:
//   clk, rst_n                 : clock, asynchronous active-low reset
//   imem_req / imem_addr       : fetch request, held stable until imem_gnt
//   imem_gnt                   : request accepted (req & gnt at the edge)
//   imem_rvalid / imem_rdata   : one response per grant, >= 1 cycle after gnt
//   redirect_valid/redirect_pc : single-cycle taken branch/jump to a new pc
//   ins_valid / ins_ready      : decode handshake for the head entry
//   ins_data / ins_pc          : head instruction and its address
//
// Handshakes: a transfer happens on a rising edge where the producer's valid
// (imem_req, ins_valid) and the consumer's ready (imem_gnt, ins_ready) are both
// high; the producer holds valid and its payload stable until that edge.
//
// Build option: define FETCH_BYPASS_EN to forward a response straight to
// decode in the cycle it arrives when the FIFO is empty (no redirect). Without
// it every response is registered in the FIFO first (one cycle of latency).
// -----------------------------------------------------------------------------
module instr_fetch_queue
  import fetch_pkg::*;
#(
  parameter int                ADDR_W   = IFQ_ADDR_W,
  parameter int                DATA_W   = IFQ_DATA_W,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              ins_valid,
  input  logic              ins_ready,
  output logic [DATA_W-1:0] ins_data,
  output logic [ADDR_W-1:0] ins_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_t      state_q, state_d;
  logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              req_q, req_d;
  logic              drop_pend_q, drop_pend_d;
  fifo_entry_t       hold_q;

  fifo_entry_t       head;
  fifo_entry_t       resp_entry;
  fifo_entry_t       shown;
  logic              fifo_empty;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_push;
  logic              fifo_pop;
  logic              resp_push;
  logic              bypass;

  // ---------------------------------------------------------------------------
  // Request state machine
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    addr_d      = addr_q;
    req_d       = req_q;
    drop_pend_d = drop_pend_q;
    resp_push   = 1'b0;

    case (state_q)
      IDLE: begin
        // No request is in flight here, so count < DEPTH is exactly the
        // "count plus in-flight slot fits" condition; responses never meet a
        // full FIFO. Any rvalid seen here is stale and ignored.
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
        end else if (fifo_count < CNT_W'(DEPTH)) begin
          state_d = REQ;
          req_d   = 1'b1;
          addr_d  = fetch_pc_q;
        end
      end

      REQ: begin
        // A redirect cannot retract a pending request: the address stays put
        // until granted and the eventual response is dropped.
        if (redirect_valid) begin
          fetch_pc_d  = redirect_pc;
          drop_pend_d = 1'b1;
        end
        if (imem_gnt) begin
          req_d       = 1'b0;
          drop_pend_d = 1'b0;
          if (redirect_valid || drop_pend_q) begin
            state_d = DROP;
          end else begin
            state_d    = WAIT;
            fetch_pc_d = fetch_pc_q + ADDR_W'(1);
          end
        end
      end

      WAIT: begin
        if (redirect_valid) begin
          fetch_pc_d = redirect_pc;
          state_d    = imem_rvalid ? IDLE : DROP;
        end else if (imem_rvalid) begin
          state_d   = IDLE;
          resp_push = 1'b1;
        end
      end

      DROP: begin
        if (redirect_valid) fetch_pc_d = redirect_pc;
        if (imem_rvalid)    state_d    = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      fetch_pc_q  <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      drop_pend_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      drop_pend_q <= drop_pend_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Prefetch FIFO and decode interface
  // ---------------------------------------------------------------------------
  always_comb begin
    resp_entry      = '0;
    resp_entry.pc   = addr_q;
    resp_entry.data = imem_rdata;
  end

`ifdef FETCH_BYPASS_EN
  assign bypass = (state_q == WAIT) && imem_rvalid && !redirect_valid && fifo_empty;
`else
  assign bypass = 1'b0;
`endif

  // A bypassed entry taken by decode in the same cycle never enters the FIFO.
  assign fifo_push = resp_push && !(bypass && ins_ready);
  assign fifo_pop  = !fifo_empty && ins_ready && !redirect_valid;

  ifq_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i   (clk),
    .rst_ni  (rst_n),
    .flush_i (redirect_valid),
    .push_i  (fifo_push),
    .entry_i (resp_entry),
    .pop_i   (fifo_pop),
    .head_o  (head),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Last head shown to decode, so ins_data/ins_pc hold while the FIFO is empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)           hold_q <= '0;
    else if (!fifo_empty) hold_q <= head;
  end

  always_comb begin
    if (bypass)          shown = resp_entry;
    else if (fifo_empty) shown = hold_q;
    else                 shown = head;
  end

  assign imem_req  = req_q;
  assign imem_addr = addr_q;
  assign ins_valid = !fifo_empty || bypass;
  assign ins_data  = shown.data;
  assign ins_pc    = shown.pc;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// -----------------------------------------------------------------------------
// tb_instr_fetch_queue
// Bench for instr_fetch_queue (default build, FETCH_BYPASS_EN undefined).
// The memory side is driven by a small responder; the expected decode stream
// is kept as a queue of {pc, data} fed by live responses and emptied by
// redirects. Directed scenarios pin the model with literal expectations, then
// a randomized run follows.
// -----------------------------------------------------------------------------
module tb_instr_fetch_queue;

  localparam int DEPTH = 4;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_gnt = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [15:0] imem_rdata = '0;
  logic        redirect_valid = 1'b0;
  logic [15:0] redirect_pc = '0;
  logic        ins_valid;
  logic        ins_ready = 1'b0;
  logic [15:0] ins_data;
  logic [15:0] ins_pc;

  instr_fetch_queue #(
    .ADDR_W   (16),
    .DATA_W   (16),
    .DEPTH    (DEPTH),
    .RESET_PC (16'h0000)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_gnt       (imem_gnt),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .ins_valid      (ins_valid),
    .ins_ready      (ins_ready),
    .ins_data       (ins_data),
    .ins_pc         (ins_pc)
  );

  // scoreboard state
  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  logic [31:0] exp_q[$];      // {pc, data} decode must see, in order
  logic [31:0] last_shown;    // what ins_pc/ins_data must hold when empty
  logic [15:0] exp_fetch;     // address the next new request must use
  logic [15:0] pend_addr;     // address of request not yet granted
  logic [15:0] out_addr;      // address of granted request awaiting data
  bit          pending, outstanding, live;
  int          lat_cnt;

  // stimulus knobs
  int          gnt_pct = 100, rdy_pct = 100, redir_pct = 0;
  int          lat_min = 1, lat_max = 1;
  bit          force_redir = 1'b0;
  logic [15:0] force_rpc = '0;

  // logs for directed expectations
  logic [15:0] iss_log[$];
  logic [31:0] pop_log[$];
  int          pop_cyc[$];

  function automatic logic [15:0] mem_word(input logic [15:0] a);
    logic [31:0] p;
    if (a == 16'h0000) return 16'h2301;
    if (a == 16'h0001) return 16'h6512;
    p = {16'h0000, a} * 32'h0000_9E37;
    return p[15:0] ^ 16'h5A5A;
  endfunction

  function automatic logic [31:0] at_iss(input int i);
    if (i < iss_log.size()) return {16'h0000, iss_log[i]};
    return 'x;
  endfunction

  function automatic logic [31:0] at_pop(input int i);
    if (i < pop_log.size()) return pop_log[i];
    return 'x;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req},  32'd0);
    chk({tag, "_addr"},  {16'b0, imem_addr}, 32'h0000);
    chk({tag, "_valid"}, {31'b0, ins_valid}, 32'd0);
    chk({tag, "_data"},  {16'b0, ins_data},  32'h0000);
    chk({tag, "_pc"},    {16'b0, ins_pc},    32'h0000);
  endtask

  // Hold reset for two cycles, clear the model, release on a falling edge.
  // With stale=1 a response is presented in the first cycle after release.
  task automatic do_reset(input bit stale);
    rst_n = 1'b0;
    imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = '0;
    redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b0;
    exp_q.delete(); last_shown = '0; exp_fetch = 16'h0000;
    pending = 1'b0; outstanding = 1'b0; live = 1'b0; lat_cnt = 0;
    iss_log.delete(); pop_log.delete(); pop_cyc.delete();
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    if (stale) begin
      imem_rvalid = 1'b1;
      imem_rdata  = 16'hDEAD;
    end
    rst_n = 1'b1;
  endtask

  // One clock cycle: compare outputs on the falling edge, drive inputs,
  // then advance the model to what the next rising edge must do.
  task automatic step();
    bit          real_rv, redir;
    logic [15:0] rpc;
    @(negedge clk);
    cyc++;

    chk("ins_valid", {31'b0, ins_valid}, {31'b0, exp_q.size() != 0});
    if (exp_q.size() != 0) last_shown = exp_q[0];
    chk("ins_pc",   {16'b0, ins_pc},   {16'b0, last_shown[31:16]});
    chk("ins_data", {16'b0, ins_data}, {16'b0, last_shown[15:0]});

    if (outstanding) begin
      chk("one_outstanding", {31'b0, imem_req}, 32'd0);
    end else if (pending) begin
      chk("req_held", {31'b0, imem_req}, 32'd1);
      chk("addr_stable", {16'b0, imem_addr}, {16'b0, pend_addr});
    end else if (imem_req) begin
      chk("req_addr", {16'b0, imem_addr}, {16'b0, exp_fetch});
      chk("req_space", {31'b0, exp_q.size() < DEPTH}, 32'd1);
      pending   = 1'b1;
      pend_addr = imem_addr;
      live      = 1'b1;
      iss_log.push_back(imem_addr);
    end

    redir = force_redir || ($urandom_range(99, 0) < redir_pct);
    rpc   = force_redir ? force_rpc :
            (($urandom_range(7, 0) == 0) ? 16'hFFFF : 16'($urandom));
    redirect_valid = redir;
    redirect_pc    = rpc;
    imem_gnt       = pending && ($urandom_range(99, 0) < gnt_pct);
    real_rv        = outstanding && (lat_cnt == 0);
    imem_rvalid    = real_rv;
    imem_rdata     = real_rv ? mem_word(out_addr) : 16'($urandom);
    ins_ready      = ($urandom_range(99, 0) < rdy_pct);

    if (redir) begin
      exp_q.delete();
      exp_fetch = rpc;
      live      = 1'b0;
    end else begin
      if (exp_q.size() != 0 && ins_ready) begin
        pop_log.push_back(exp_q[0]);
        pop_cyc.push_back(cyc);
        void'(exp_q.pop_front());
      end
      if (real_rv && live) exp_q.push_back({out_addr, imem_rdata});
    end

    if (real_rv) outstanding = 1'b0;
    else if (outstanding) lat_cnt--;

    if (imem_gnt) begin
      pending     = 1'b0;
      outstanding = 1'b1;
      out_addr    = pend_addr;
      lat_cnt     = $urandom_range(lat_max, lat_min) - 1;
      if (live) exp_fetch = pend_addr + 16'd1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int i3, p0;

    // ---- basic fetch, 1-cycle memory, decode always ready ------------------
    do_reset(1'b0);
    for (int n = 0; n < 60 && pop_log.size() < 2; n++) step();
    chk("t1_done", {31'b0, pop_log.size() >= 2}, 32'd1);
    chk("t1_iss0", at_iss(0), 32'h0000_0000);
    chk("t1_iss1", at_iss(1), 32'h0000_0001);
    chk("t1_pop0", at_pop(0), 32'h0000_2301);
    chk("t1_pop1", at_pop(1), 32'h0001_6512);
    if (pop_cyc.size() >= 2) chk("t1_rate", pop_cyc[1] - pop_cyc[0], 32'd3);

    // ---- decode stalled: exactly DEPTH requests, then one pop frees one ----
    do_reset(1'b0);
    rdy_pct = 0;
    repeat (40) step();
    chk("t2_issued", iss_log.size(), 32'd4);
    for (int i = 0; i < 4; i++) chk("t2_addr", at_iss(i), i);
    chk("t2_req_idle", {31'b0, imem_req}, 32'd0);
    rdy_pct = 100;
    step();
    rdy_pct = 0;
    repeat (10) step();
    chk("t2_issued_after_pop", iss_log.size(), 32'd5);
    chk("t2_addr4", at_iss(4), 32'h0000_0004);

    // ---- redirect while waiting for the addr-5 response --------------------
    do_reset(1'b0);
    rdy_pct = 100; lat_min = 3; lat_max = 3;
    for (int n = 0; n < 200 && !(outstanding && out_addr == 16'd5); n++) step();
    chk("t3_reached", {31'b0, outstanding && out_addr == 16'd5}, 32'd1);
    i3 = iss_log.size();
    p0 = pop_log.size();
    force_redir = 1'b1; force_rpc = 16'h0040;
    step();
    force_redir = 1'b0;
    @(posedge clk); #1;
    chk("t3_flush_valid", {31'b0, ins_valid}, 32'd0);
    for (int n = 0; n < 100 && pop_log.size() <= p0; n++) step();
    chk("t3_prev_iss", at_iss(i3 - 1), 32'h0000_0005);
    chk("t3_next_iss", at_iss(i3), 32'h0000_0040);
    chk("t3_next_pop", at_pop(p0), {16'h0040, mem_word(16'h0040)});
    lat_min = 1; lat_max = 1;

    // ---- grant withheld 3 cycles, redirect during REQ ----------------------
    do_reset(1'b0);
    gnt_pct = 0;
    step();
    force_redir = 1'b1; force_rpc = 16'h0010;
    step();
    force_redir = 1'b0;
    step();
    chk("t4_req_held", {31'b0, imem_req}, 32'd1);
    chk("t4_addr_hold", {16'b0, imem_addr}, 32'h0000_0000);
    gnt_pct = 100;
    for (int n = 0; n < 60 && pop_log.size() < 1; n++) step();
    chk("t4_iss0", at_iss(0), 32'h0000_0000);
    chk("t4_iss1", at_iss(1), 32'h0000_0010);
    chk("t4_pop0", at_pop(0), {16'h0010, mem_word(16'h0010)});

    // ---- pc wrap at 16'hFFFF ----------------------------------------------
    do_reset(1'b0);
    for (int n = 0; n < 60 && pop_log.size() < 1; n++) step();
    force_redir = 1'b1; force_rpc = 16'hFFFF;
    step();
    force_redir = 1'b0;
    p0 = pop_log.size();
    for (int n = 0; n < 60 && pop_log.size() < p0 + 2; n++) step();
    chk("t5_pop_ffff", at_pop(p0), {16'hFFFF, mem_word(16'hFFFF)});
    chk("t5_pop_wrap", at_pop(p0 + 1), {16'h0000, mem_word(16'h0000)});

    // ---- asynchronous reset during WAIT, stale response afterwards ---------
    do_reset(1'b0);
    lat_min = 4; lat_max = 4;
    for (int n = 0; n < 60 && !(outstanding && out_addr == 16'd2); n++) step();
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("async_reset");
    lat_min = 1; lat_max = 1;
    do_reset(1'b1);
    for (int n = 0; n < 60 && pop_log.size() < 1; n++) step();
    chk("t6_iss0", at_iss(0), 32'h0000_0000);
    chk("t6_pop0", at_pop(0), 32'h0000_2301);

    // ---- randomized run ----------------------------------------------------
    do_reset(1'b0);
    gnt_pct = 70; rdy_pct = 70; redir_pct = 3; lat_min = 1; lat_max = 4;
    repeat (4000) step();
    chk("rand_progress", {31'b0, pop_log.size() > 200}, 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_fetch_queue.md
Name: instr_fetch_queue

Overview:
- Fetch stage directly upstream of the single-cycle decode/execute datapath; replaces the bare PC register and combinational instruction-memory read.
- Issues word-addressed fetches to an instruction memory with variable latency over a req/gnt/rvalid handshake, and buffers returned instructions in a small prefetch FIFO.
- Delivers {instruction, pc} to decode with valid/ready.
- Flushes on branch/jump redirect and discards any in-flight stale response.

Parameters:
- ADDR_W, 16, instruction address width (word address; PC increments by 1).
- DATA_W, 16, instruction width.
- DEPTH, 4, prefetch FIFO entries; power of two, at least 2.
- RESET_PC, 16'h0000, first fetch address after reset.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- imem_req  out  1  fetch request; held with imem_addr stable until imem_gnt.
- imem_addr  out  ADDR_W  fetch word address.
- imem_gnt  in  1  request accepted this cycle (req and gnt both high at the edge).
- imem_rvalid  in  1  response valid; at least 1 cycle after gnt; exactly one response per grant.
- imem_rdata  in  DATA_W  response instruction.
- redirect_valid  in  1  branch/jump taken; single-cycle pulse.
- redirect_pc  in  ADDR_W  new fetch address.
- ins_valid  out  1  head entry valid to decode.
- ins_ready  in  1  decode accepts the head entry.
- ins_data  out  DATA_W  head instruction.
- ins_pc  out  ADDR_W  address of the head instruction.

Behaviour:
- Reset: imem_req=0, imem_addr=RESET_PC, ins_valid=0, ins_data=0, ins_pc=0, FIFO empty, fetch_pc=RESET_PC, state IDLE.
- One outstanding request maximum.
- State machine:
  - IDLE to REQ when (count + 0) < DEPTH and no redirect this cycle; imem_req registered high, imem_addr=fetch_pc.
  - REQ to WAIT on imem_gnt; fetch_pc <= fetch_pc+1, wrapping 16'hFFFF to 16'h0000.
  - WAIT to IDLE on imem_rvalid; {imem_rdata, issued addr} pushed to FIFO.
  - DROP to IDLE on imem_rvalid; data discarded.
- Space check: a request is issued only if count + 1 <= DEPTH, counting the in-flight slot. A response therefore never finds the FIFO full, and full-push is impossible by construction.
- Redirect has priority over push and pop in the same cycle. On redirect:
  - FIFO cleared, ins_valid=0 from the next cycle, fetch_pc <= redirect_pc.
  - From REQ: imem_req and imem_addr stay stable until gnt, then go to DROP rather than WAIT.
  - From WAIT: go to DROP; an rvalid in the redirect cycle itself is discarded and the FSM goes to IDLE.
  - From DROP: stay in DROP, pc updated.
  - From IDLE: pc updated, request issued the following cycle.
- Latency: rvalid at edge N makes ins_valid=1 after edge N, i.e. visible in cycle N+1. Minimum back-to-back throughput is one instruction per 3 cycles with a 1-cycle memory: REQ, WAIT, IDLE.
- FIFO: pop when ins_valid and ins_ready. Simultaneous push and pop keeps count unchanged. Pop when empty is ignored. ins_data/ins_pc come from the head entry; they hold their last values when empty (ins_valid=0 qualifies them).
- Reset asserted mid-operation: immediate return to reset values; a late imem_rvalid arriving after rst_n rises while in IDLE is ignored.

Optional Feature:
- FETCH_BYPASS_EN:
  - When defined and the FIFO is empty in state WAIT, imem_rvalid=1 and no redirect: ins_valid, ins_data and ins_pc are driven combinationally from the response in the same cycle.
  - If ins_ready=1 in that cycle, the entry is not written to the FIFO.
  - Without the macro, all responses pass through the FIFO with 1-cycle latency as above.

Decomposition:
- Package fetch_pkg: fetch_state_t enum {IDLE, REQ, WAIT, DROP}; default RESET_PC; fifo_entry_t struct {pc, data}.
- Sub-module ifq_fifo: synchronous FIFO of fifo_entry_t with DEPTH, push, pop, flush, count; flush has priority over push.

Test Plan:
- Reset then memory with 1-cycle latency returning 16'h2301 at 0 and 16'h6512 at 1, ins_ready=1: requests to 0 then 1; decode sees {16'h2301, pc 0} then {16'h6512, pc 1}.
- ins_ready=0, DEPTH=4: exactly 4 requests issued (addresses 0..3), imem_req stays 0 afterwards; one pop, then request to 4 issues.
- Redirect to 16'h0040 while in WAIT for addr 5: the addr-5 response is dropped, ins_valid=0, next req addr=16'h0040, and ins_pc of the next output is 16'h0040.
- imem_gnt withheld 3 cycles, redirect to 16'h0010 during REQ: imem_addr stays stable until gnt, that response is discarded, then req to 16'h0010.
- fetch_pc=16'hFFFF: fetch returns pc 16'hFFFF, next request to 16'h0000.
- rst_n pulsed low during WAIT: outputs return to reset values asynchronously; after release the first req is to RESET_PC and the stale rvalid is ignored.
